// File: rtl/store_check_unit.sv
// store_check_unit: snoops data-memory stores from the core and checks them
// against a programmable table of expected (address, data) pairs.
// The end-of-program sentinel store decides PASS or FAIL.
//
// Optional feature macro: STORE_CHECK_TIMEOUT_EN
//   defined   - a RUN-time watchdog forces FAIL after TIMEOUT cycles
//   undefined - no watchdog; RUN waits indefinitely for the sentinel
//
// state | meaning
// IDLE  | table programming allowed, stores ignored
// RUN   | stores are checked against the table and the sentinel
// PASS  | sentinel seen with every valid entry hit; status held
// FAIL  | sentinel seen early, stray sentinel data, or watchdog; status held
module store_check_unit #(
  parameter int          DEPTH    = 64,
  parameter logic [31:0] END_ADR  = 32'd40,
  parameter logic [31:0] END_DATA = 32'd30,
  parameter int unsigned TIMEOUT  = 100000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       MemWrite,
  input  logic [31:0]                DataAdr,
  input  logic [31:0]                WriteData,
  input  logic [3:0]                 byteEnable,
  input  logic                       cfg_we,
  input  logic [$clog2(DEPTH)-1:0]   cfg_idx,
  input  logic [31:0]                cfg_adr,
  input  logic [31:0]                cfg_data,
  input  logic                       cfg_valid,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       fail,
  output logic [$clog2(DEPTH+1)-1:0] pass_count,
  output logic [31:0]                fail_adr,
  output logic [31:0]                fail_data
);

  localparam int IDXW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam logic [CNTW-1:0] MAX_COUNT = CNTW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  state_t state;

  logic [31:0]      tblAdr  [DEPTH];
  logic [31:0]      tblData [DEPTH];
  logic [DEPTH-1:0] validBits;
  logic [DEPTH-1:0] hitBits;

  logic            fullWord;
  logic            storeSeen;
  logic            isSentinel;
  logic            isStray;
  logic            allHit;
  logic            matchFound;
  logic [IDXW-1:0] matchIdx;

`ifdef STORE_CHECK_TIMEOUT_EN
  logic [31:0] cycleCnt;
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);
`else
  logic [31:0] unusedTimeout;
  assign unusedTimeout = TIMEOUT;
`endif

  // Sentinel rules only consider full-word stores; partial stores are ignored outright.
  assign fullWord   = (byteEnable == 4'b1111);
  assign storeSeen  = MemWrite && fullWord;
  assign isSentinel = (DataAdr == END_ADR) && (WriteData == END_DATA);
  assign isStray    = (DataAdr != END_ADR) && (WriteData == END_DATA);
  assign allHit     = &(~validBits | hitBits);

  // Lowest-index valid, not-yet-hit entry matching the current store.
  always_comb begin
    matchFound = 1'b0;
    matchIdx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!matchFound && validBits[i] && !hitBits[i] &&
          (tblAdr[i] == DataAdr) && (tblData[i] == WriteData)) begin
        matchFound = 1'b1;
        matchIdx   = IDXW'(i);
      end
    end
  end

  // Table address/data storage; written only while idle. Validity lives in validBits.
  always_ff @(posedge clk) begin
    if (state == IDLE && cfg_we) begin
      tblAdr[cfg_idx]  <= cfg_adr;
      tblData[cfg_idx] <= cfg_data;
    end
  end

  // Checker FSM with registered status, hit tracking and failure capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      pass_count <= '0;
      fail_adr   <= '0;
      fail_data  <= '0;
      validBits  <= '0;
      hitBits    <= '0;
`ifdef STORE_CHECK_TIMEOUT_EN
      cycleCnt   <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (cfg_we) begin
            validBits[cfg_idx] <= cfg_valid;
            hitBits[cfg_idx]   <= 1'b0;
          end
          if (start) begin
            state      <= RUN;
            busy       <= 1'b1;
            hitBits    <= '0;
            pass_count <= '0;
`ifdef STORE_CHECK_TIMEOUT_EN
            cycleCnt   <= '0;
`endif
          end
        end

        RUN: begin
`ifdef STORE_CHECK_TIMEOUT_EN
          cycleCnt <= cycleCnt + 32'd1;
`endif
          if (start) begin
            // Restart keeps the last failure capture for post-mortem reads.
            hitBits    <= '0;
            pass_count <= '0;
`ifdef STORE_CHECK_TIMEOUT_EN
            cycleCnt   <= '0;
`endif
          end
`ifdef STORE_CHECK_TIMEOUT_EN
          else if (cycleCnt == TIMEOUT_LAST) begin
            state     <= FAIL;
            busy      <= 1'b0;
            done      <= 1'b1;
            fail      <= 1'b1;
            fail_adr  <= 32'hFFFF_FFFF;
            fail_data <= cycleCnt + 32'd1;
          end
`endif
          else if (storeSeen && isSentinel) begin
            busy <= 1'b0;
            done <= 1'b1;
            if (allHit) begin
              state <= PASS;
              pass  <= 1'b1;
            end else begin
              state     <= FAIL;
              fail      <= 1'b1;
              fail_adr  <= DataAdr;
              fail_data <= WriteData;
            end
          end else if (storeSeen && isStray) begin
            state     <= FAIL;
            busy      <= 1'b0;
            done      <= 1'b1;
            fail      <= 1'b1;
            fail_adr  <= DataAdr;
            fail_data <= WriteData;
          end else if (storeSeen && matchFound) begin
            hitBits[matchIdx] <= 1'b1;
            if (pass_count != MAX_COUNT) begin
              pass_count <= pass_count + 1'b1;
            end
          end
        end

        PASS, FAIL: begin
          if (start) begin
            state      <= RUN;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            hitBits    <= '0;
            pass_count <= '0;
`ifdef STORE_CHECK_TIMEOUT_EN
            cycleCnt   <= '0;
`endif
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_check_unit.sv
// Self-checking bench for store_check_unit: directed vector table, hand-written
// reset/timeout sequences, and randomized stores against a behavioural model.
module tb_store_check_unit;

  localparam int DEPTH = 64;
  localparam int IDXW  = $clog2(DEPTH);
  localparam int CNTW  = $clog2(DEPTH + 1);
  localparam logic [31:0] END_ADR  = 32'd40;
  localparam logic [31:0] END_DATA = 32'd30;
  localparam int TMO = 50;

  logic            clk = 1'b0;
  logic            reset;
  logic            MemWrite;
  logic [31:0]     DataAdr;
  logic [31:0]     WriteData;
  logic [3:0]      byteEnable;
  logic            cfg_we;
  logic [IDXW-1:0] cfg_idx;
  logic [31:0]     cfg_adr;
  logic [31:0]     cfg_data;
  logic            cfg_valid;
  logic            start;
  logic            busy, done, pass, fail;
  logic [CNTW-1:0] pass_count;
  logic [31:0]     fail_adr, fail_data;

  always #5 clk = ~clk;

  store_check_unit #(
    .DEPTH(DEPTH), .END_ADR(END_ADR), .END_DATA(END_DATA), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .byteEnable(byteEnable), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_adr(cfg_adr), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .start(start), .busy(busy), .done(done),
    .pass(pass), .fail(fail), .pass_count(pass_count), .fail_adr(fail_adr),
    .fail_data(fail_data)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model: mode 0=idle 1=run 2=pass 3=fail
  int          mMode;
  bit          mValid [DEPTH];
  bit          mHit   [DEPTH];
  logic [31:0] mAdr   [DEPTH];
  logic [31:0] mData  [DEPTH];
  logic [31:0] mFailAdr, mFailData;

  typedef struct packed {
    logic        st;
    logic        we;
    logic [31:0] adr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [7:0]  cnt;
    logic        busy;
    logic        pass;
    logic        fail;
    logic [31:0] fAdr;
    logic [31:0] fData;
  } vec_t;

  vec_t vecs [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int hitCount();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (mValid[i] && mHit[i]) n++;
    return (n > DEPTH) ? DEPTH : n;
  endfunction

  function automatic bit everyValidHit();
    for (int i = 0; i < DEPTH; i++) if (mValid[i] && !mHit[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic modelClear();
    mMode = 0;
    mFailAdr = '0;
    mFailData = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mValid[i] = 1'b0;
      mHit[i]   = 1'b0;
      mAdr[i]   = '0;
      mData[i]  = '0;
    end
  endtask

  task automatic modelStep(input logic st, input logic we, input logic [31:0] adr,
                           input logic [31:0] data, input logic [3:0] be);
    bit taken;
    if (st) begin
      for (int i = 0; i < DEPTH; i++) mHit[i] = 1'b0;
      mMode = 1;
    end else if (mMode == 1 && we && be == 4'hF) begin
      if (data == END_DATA) begin
        if (adr == END_ADR && everyValidHit()) mMode = 2;
        else begin
          mMode = 3;
          mFailAdr = adr;
          mFailData = data;
        end
      end else begin
        taken = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
          if (!taken && mValid[i] && !mHit[i] && mAdr[i] == adr && mData[i] == data) begin
            mHit[i] = 1'b1;
            taken = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic checkModel(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'(mMode == 1));
    check({tag, "_done"}, 32'(done), 32'(mMode >= 2));
    check({tag, "_pass"}, 32'(pass), 32'(mMode == 2));
    check({tag, "_fail"}, 32'(fail), 32'(mMode == 3));
    check({tag, "_cnt"}, 32'(pass_count), 32'(hitCount()));
    check({tag, "_fadr"}, fail_adr, mFailAdr);
    check({tag, "_fdata"}, fail_data, mFailData);
  endtask

  task automatic cfgWrite(input int idx, input logic [31:0] adr, input logic [31:0] data,
                          input logic valid);
    cfg_we = 1'b1;
    cfg_idx = IDXW'(idx);
    cfg_adr = adr;
    cfg_data = data;
    cfg_valid = valid;
    tick();
    cfg_we = 1'b0;
    mValid[idx] = valid;
    mHit[idx] = 1'b0;
    mAdr[idx] = adr;
    mData[idx] = data;
  endtask

  task automatic doStore(input logic st, input logic we, input logic [31:0] adr,
                         input logic [31:0] data, input logic [3:0] be);
    start = st;
    MemWrite = we;
    DataAdr = adr;
    WriteData = data;
    byteEnable = be;
    tick();
    start = 1'b0;
    MemWrite = 1'b0;
    modelStep(st, we, adr, data, be);
  endtask

  task automatic doReset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    modelClear();
    tick();
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_fail"}, 32'(fail), 32'd0);
    check({tag, "_cnt"}, 32'(pass_count), 32'd0);
    check({tag, "_fadr"}, fail_adr, 32'd0);
    check({tag, "_fdata"}, fail_data, 32'd0);
  endtask

  initial begin
    logic [31:0] adr, data;
    logic [3:0]  be;
    logic        st, we;
    int          r, nEnt;

    reset = 1'b1;
    MemWrite = 1'b0; DataAdr = '0; WriteData = '0; byteEnable = '0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_adr = '0; cfg_data = '0; cfg_valid = 1'b0;
    start = 1'b0;
    modelClear();
    tick();
    checkAllZero("reset");
    reset = 1'b0;
    tick();

    // Directed vectors: {start, we, adr, data, be, cnt, busy, pass, fail, fAdr, fData}
    vecs[0]  = '{1'b1, 1'b0, 32'd0,   32'd0,    4'hF, 8'd0, 1'b1, 1'b0, 1'b0, 32'd0,   32'd0};
    vecs[1]  = '{1'b0, 1'b1, 32'd100, 32'd25,   4'hF, 8'd1, 1'b1, 1'b0, 1'b0, 32'd0,   32'd0};
    vecs[2]  = '{1'b0, 1'b1, 32'd104, 32'd4096, 4'hF, 8'd2, 1'b1, 1'b0, 1'b0, 32'd0,   32'd0};
    vecs[3]  = '{1'b0, 1'b1, 32'd40,  32'd30,   4'hF, 8'd2, 1'b0, 1'b1, 1'b0, 32'd0,   32'd0};
    vecs[4]  = '{1'b1, 1'b0, 32'd0,   32'd0,    4'hF, 8'd0, 1'b1, 1'b0, 1'b0, 32'd0,   32'd0};
    vecs[5]  = '{1'b0, 1'b1, 32'd100, 32'd25,   4'hF, 8'd1, 1'b1, 1'b0, 1'b0, 32'd0,   32'd0};
    vecs[6]  = '{1'b0, 1'b1, 32'd100, 32'd25,   4'hF, 8'd1, 1'b1, 1'b0, 1'b0, 32'd0,   32'd0};
    vecs[7]  = '{1'b0, 1'b1, 32'd100, 32'd25,   4'hF, 8'd1, 1'b1, 1'b0, 1'b0, 32'd0,   32'd0};
    vecs[8]  = '{1'b0, 1'b1, 32'd104, 32'd4096, 4'h1, 8'd1, 1'b1, 1'b0, 1'b0, 32'd0,   32'd0};
    vecs[9]  = '{1'b0, 1'b1, 32'd40,  32'd30,   4'hF, 8'd1, 1'b0, 1'b0, 1'b1, 32'd40,  32'd30};
    vecs[10] = '{1'b1, 1'b0, 32'd0,   32'd0,    4'hF, 8'd0, 1'b1, 1'b0, 1'b0, 32'd40,  32'd30};
    vecs[11] = '{1'b0, 1'b1, 32'd100, 32'd25,   4'h1, 8'd0, 1'b1, 1'b0, 1'b0, 32'd40,  32'd30};
    vecs[12] = '{1'b0, 1'b1, 32'd120, 32'd30,   4'hF, 8'd0, 1'b0, 1'b0, 1'b1, 32'd120, 32'd30};
    vecs[13] = '{1'b1, 1'b1, 32'd100, 32'd25,   4'hF, 8'd0, 1'b1, 1'b0, 1'b0, 32'd120, 32'd30};
    vecs[14] = '{1'b0, 1'b1, 32'd100, 32'd25,   4'hF, 8'd1, 1'b1, 1'b0, 1'b0, 32'd120, 32'd30};
    vecs[15] = '{1'b0, 1'b0, 32'd104, 32'd4096, 4'hF, 8'd1, 1'b1, 1'b0, 1'b0, 32'd120, 32'd30};

    cfgWrite(0, 32'd100, 32'd25, 1'b1);
    cfgWrite(1, 32'd104, 32'd4096, 1'b1);
    for (int i = 0; i < 16; i++) begin
      doStore(vecs[i].st, vecs[i].we, vecs[i].adr, vecs[i].data, vecs[i].be);
      check($sformatf("vec%0d_cnt", i), 32'(pass_count), 32'(vecs[i].cnt));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].pass | vecs[i].fail));
      check($sformatf("vec%0d_pass", i), 32'(pass), 32'(vecs[i].pass));
      check($sformatf("vec%0d_fail", i), 32'(fail), 32'(vecs[i].fail));
      check($sformatf("vec%0d_fadr", i), fail_adr, vecs[i].fAdr);
      check($sformatf("vec%0d_fdata", i), fail_data, vecs[i].fData);
    end

    // Reset mid-RUN (one hit, failure capture nonzero) clears everything at once.
    #2 reset = 1'b1;
    #1;
    checkAllZero("midreset");
    @(posedge clk);
    #1 reset = 1'b0;
    modelClear();
    cfgWrite(0, 32'd200, 32'd7, 1'b1);
    doStore(1'b1, 1'b0, 32'd0, 32'd0, 4'hF);
    doStore(1'b0, 1'b1, 32'd100, 32'd25, 4'hF);
    check("old_entry_cnt", 32'(pass_count), 32'd0);
    doStore(1'b0, 1'b1, 32'd104, 32'd4096, 4'hF);
    check("old_entry1_cnt", 32'(pass_count), 32'd0);
    doStore(1'b0, 1'b1, 32'd200, 32'd7, 4'hF);
    check("new_entry_cnt", 32'(pass_count), 32'd1);
    check("new_entry_busy", 32'(busy), 32'd1);

    // Watchdog behaviour.
    doReset();
    doStore(1'b1, 1'b0, 32'd0, 32'd0, 4'hF);
`ifdef STORE_CHECK_TIMEOUT_EN
    for (int i = 0; i < TMO - 1; i++) tick();
    check("tmo_before_busy", 32'(busy), 32'd1);
    check("tmo_before_fail", 32'(fail), 32'd0);
    tick();
    check("tmo_fail", 32'(fail), 32'd1);
    check("tmo_done", 32'(done), 32'd1);
    check("tmo_fadr", fail_adr, 32'hFFFF_FFFF);
    check("tmo_fdata", fail_data, 32'(TMO));
`else
    for (int i = 0; i < 1000; i++) tick();
    check("notmo_busy", 32'(busy), 32'd1);
    check("notmo_done", 32'(done), 32'd0);
`endif

    // Randomized episodes against the behavioural model.
    for (int ep = 0; ep < 8; ep++) begin
      doReset();
      nEnt = $urandom_range(2, 10);
      for (int k = 0; k < nEnt; k++) begin
        cfgWrite($urandom_range(0, 15), 32'h1000 + 32'(4 * $urandom_range(0, 5)),
                 32'd1000 + 32'($urandom_range(0, 2)), ($urandom_range(0, 4) != 0));
      end
      doStore(1'b1, 1'b0, 32'd0, 32'd0, 4'hF);
      checkModel($sformatf("ep%0d_start", ep));
      for (int c = 0; c < 80; c++) begin
        r  = $urandom_range(0, 99);
        st = (r < 2) || (mMode >= 2 && r < 30);
        we = ($urandom_range(0, 3) != 0);
        adr  = 32'h1000 + 32'(4 * $urandom_range(0, 5));
        data = 32'd1000 + 32'($urandom_range(0, 2));
        be   = ($urandom_range(0, 6) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
        r = $urandom_range(0, 99);
        if (r < 5) begin
          adr = END_ADR; data = END_DATA; be = 4'hF;
        end else if (r < 7) begin
          adr = 32'h2000 + 32'($urandom_range(0, 255)); data = END_DATA; be = 4'hF;
        end
        doStore(st, we, adr, data, be);
        checkModel($sformatf("ep%0d_c%0d", ep, c));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
